// File: rtl/axi_stream_extract_header.sv
// Purpose : strips a 1..W byte header off the first beat of each AXI-Stream packet and
//           re-packs the remaining payload MSB-first into full beats.
// Latency : 1 clk from input accept to payload/header output (both registered).
// Backpr. : ready_in follows payload-register space; the first beat of a packet also waits
//           for the previous header to be taken, body beats never wait on the header port.
// Ports   : clk/rst_n (async active-low); valid_in/data_in/keep_in/last_in/ready_in input
//           stream; hdr_len = header bytes - 1; valid_out/data_out/keep_out/last_out/ready_out
//           payload stream; valid_hdr/data_hdr/keep_hdr/ready_hdr extracted header.
module axi_stream_extract_header #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    ready_in,
   input  logic [BYTE_CNT_WD-1:0]  hdr_len,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out,
   output logic                    valid_hdr,
   output logic [DATA_WD-1:0]      data_hdr,
   output logic [DATA_BYTE_WD-1:0] keep_hdr,
   input  logic                    ready_hdr
);

   // One extra bit so that S = W is representable.
   localparam int SW = BYTE_CNT_WD + 1;

   typedef enum logic [1:0] {HDR, BODY, FLUSH} state_t;

   state_t                  state;
   logic [SW-1:0]           shift_s;    // header length S latched for the current packet
   logic [DATA_WD-1:0]      residual;   // tail bytes of the last beat, already MSB-aligned
   logic [DATA_BYTE_WD-1:0] res_keep;

   function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
      logic [DATA_WD-1:0] m;
      m = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
      return m;
   endfunction

   logic                    out_free;
   logic                    hdr_free;
   logic                    accept;
   logic [SW-1:0]           s_new;
   logic [SW-1:0]           cur_s;
   logic [SW-1:0]           r_cur;
   logic [DATA_WD-1:0]      in_dat_m;
   logic [DATA_WD-1:0]      nxt_res;
   logic [DATA_BYTE_WD-1:0] nxt_res_keep;
   logic [DATA_WD-1:0]      merged_dat;
   logic [DATA_BYTE_WD-1:0] merged_keep;
   logic [DATA_BYTE_WD-1:0] hdr_keep_mask;

   assign out_free = !valid_out || ready_out;
   assign hdr_free = !valid_hdr || ready_hdr;

   always_comb begin
      ready_in = 1'b0;
      case (state)
         HDR:     ready_in = out_free && hdr_free;
         BODY:    ready_in = out_free;
         default: ready_in = 1'b0;
      endcase
   end

   assign accept = valid_in && ready_in;

   // Disabled bytes are zeroed on entry so every downstream register is clean.
   assign in_dat_m      = data_in & byte_mask(keep_in);
   assign s_new         = SW'(hdr_len) + SW'(1);
   assign cur_s         = (state == HDR) ? s_new : shift_s;
   assign r_cur         = SW'(DATA_BYTE_WD) - shift_s;
   // Shifting by the full width yields 0, so S = W leaves no residual and the
   // merge below degenerates to a plain pass-through.
   assign nxt_res       = in_dat_m << {cur_s, 3'b000};
   assign nxt_res_keep  = keep_in << cur_s;
   assign merged_dat    = residual | (in_dat_m >> {r_cur, 3'b000});
   assign merged_keep   = res_keep | (keep_in >> r_cur);
   assign hdr_keep_mask = ~({DATA_BYTE_WD{1'b1}} >> s_new);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HDR;
         shift_s   <= '0;
         residual  <= '0;
         res_keep  <= '0;
         valid_out <= 1'b0;
         data_out  <= '0;
         keep_out  <= '0;
         last_out  <= 1'b0;
         valid_hdr <= 1'b0;
         data_hdr  <= '0;
         keep_hdr  <= '0;
      end else begin
         // Default drops; a load below re-asserts in the same cycle (no bubble).
         if (ready_hdr) valid_hdr <= 1'b0;
         if (out_free)  valid_out <= 1'b0;

         case (state)
            HDR: begin
               if (accept) begin
                  shift_s   <= s_new;
                  valid_hdr <= 1'b1;
                  data_hdr  <= in_dat_m & byte_mask(hdr_keep_mask);
                  keep_hdr  <= keep_in & hdr_keep_mask;
                  residual  <= nxt_res;
                  res_keep  <= nxt_res_keep;
                  if (!last_in) begin
                     state <= BODY;
                  end else if (nxt_res_keep != '0) begin
                     // Single-beat packet with payload left after the header.
                     valid_out <= 1'b1;
                     data_out  <= nxt_res;
                     keep_out  <= nxt_res_keep;
                     last_out  <= 1'b1;
                  end
               end
            end
            BODY: begin
               if (accept) begin
                  valid_out <= 1'b1;
                  data_out  <= merged_dat;
                  keep_out  <= merged_keep;
                  residual  <= nxt_res;
                  res_keep  <= nxt_res_keep;
                  if (last_in && nxt_res_keep != '0) begin
                     last_out <= 1'b0;
                     state    <= FLUSH;
                  end else if (last_in) begin
                     last_out <= 1'b1;
                     state    <= HDR;
                  end else begin
                     last_out <= 1'b0;
                  end
               end
            end
            FLUSH: begin
               if (out_free) begin
                  valid_out <= 1'b1;
                  data_out  <= residual;
                  keep_out  <= res_keep;
                  last_out  <= 1'b1;
                  state     <= HDR;
               end
            end
            default: state <= HDR;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Purpose : self-checking bench for axi_stream_extract_header at W=4.
// Latency : n/a (bench).
// Backpr. : drives random / stalled ready_out and a held-off ready_hdr.
module tb_axi_stream_extract_header;
   localparam int DW = 32;
   localparam int W  = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          valid_in, last_in, ready_in;
   logic [DW-1:0] data_in;
   logic [W-1:0]  keep_in;
   logic [CW-1:0] hdr_len;
   logic          valid_out, last_out, ready_out;
   logic [DW-1:0] data_out;
   logic [W-1:0]  keep_out;
   logic          valid_hdr, ready_hdr;
   logic [DW-1:0] data_hdr;
   logic [W-1:0]  keep_hdr;

   always #5 clk = ~clk;

   axi_stream_extract_header #(.DATA_WD(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
      .ready_in(ready_in), .hdr_len(hdr_len),
      .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
      .ready_out(ready_out),
      .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr), .ready_hdr(ready_hdr)
   );

   typedef struct packed {
      logic [DW-1:0] d;
      logic [W-1:0]  k;
      logic          l;
   } beat_t;

   beat_t in_q[$], exp_q[$], exp_h[$], obs_q[$], obs_h[$], lit_q[$];
   int    tests = 0;
   int    fails = 0;
   bit    mute = 1'b0;
   bit    rand_rdy = 1'b0;
   int    stall_out = 0;
   int    stall_hdr = 0;

   function automatic beat_t mk(input logic [DW-1:0] d, input logic [W-1:0] k, input logic l);
      beat_t b;
      b.d = d; b.k = k; b.l = l;
      return b;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Byte-level reference: collect enabled bytes, drop the first S of beat 0 as
   // header, then chunk what is left into W-byte beats.
   task automatic build_model(input int s);
      logic [7:0] by[$];
      int    n0, drop, c;
      beat_t b;
      n0 = 0;
      for (int j = 0; j < in_q.size(); j++)
         for (int i = W - 1; i >= 0; i--)
            if (in_q[j].k[i]) begin
               by.push_back(in_q[j].d[8*i +: 8]);
               if (j == 0) n0++;
            end
      drop = (n0 < s) ? n0 : s;
      b = '0;
      for (int i = 0; i < drop; i++) begin
         b.d[8*(W-1-i) +: 8] = by.pop_front();
         b.k[W-1-i] = 1'b1;
      end
      exp_h.push_back(b);
      while (by.size() > 0) begin
         b = '0;
         c = (by.size() > W) ? W : by.size();
         for (int i = 0; i < c; i++) begin
            b.d[8*(W-1-i) +: 8] = by.pop_front();
            b.k[W-1-i] = 1'b1;
         end
         b.l = (by.size() == 0);
         exp_q.push_back(b);
      end
   endtask

   task automatic drive_beat(input beat_t b, input logic [CW-1:0] hl, output int waited);
      valid_in = 1'b1; data_in = b.d; keep_in = b.k; last_in = b.l; hdr_len = hl;
      waited = 0;
      @(negedge clk);
      while (!ready_in && waited < 300) begin
         waited++;
         @(negedge clk);
      end
      if (!ready_in) chk("in_accept_timeout", 64'(waited), 64'(0));
      @(posedge clk); #1;
      valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
   endtask

   task automatic run_pkt(input int s, output int first_wait);
      int w;
      first_wait = 0;
      build_model(s);
      for (int j = 0; j < in_q.size(); j++) begin
         drive_beat(in_q[j], CW'(s - 1), w);
         if (j == 0) first_wait = w;
      end
      in_q.delete();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() + exp_h.size()) != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      chk("drain_left", 64'(exp_q.size() + exp_h.size()), 64'(0));
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic expect_lits(input string name, input beat_t hlit);
      chk({name, "_nbeats"}, 64'(obs_q.size()), 64'(lit_q.size()));
      for (int i = 0; i < lit_q.size() && i < obs_q.size(); i++)
         chk({name, "_beat"}, 64'(obs_q[i]), 64'(lit_q[i]));
      chk({name, "_nhdr"}, 64'(obs_h.size()), 64'(1));
      if (obs_h.size() > 0) chk({name, "_hdr"}, 64'(obs_h[0]), 64'(hlit));
      obs_q.delete(); obs_h.delete(); lit_q.delete();
   endtask

   task automatic load_case1(input logic [DW-1:0] last_d, input logic [W-1:0] last_k);
      in_q.push_back(mk(32'hAABBCCDD, 4'hF, 1'b0));
      in_q.push_back(mk(32'h11223344, 4'hF, 1'b0));
      in_q.push_back(mk(last_d, last_k, 1'b1));
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_valid_out"}, 64'(valid_out), 64'(0));
      chk({name, "_data_out"},  64'(data_out),  64'(0));
      chk({name, "_keep_out"},  64'(keep_out),  64'(0));
      chk({name, "_last_out"},  64'(last_out),  64'(0));
      chk({name, "_valid_hdr"}, 64'(valid_hdr), 64'(0));
      chk({name, "_data_hdr"},  64'(data_hdr),  64'(0));
      chk({name, "_keep_hdr"},  64'(keep_hdr),  64'(0));
   endtask

   // Ready generators: optional 50% random, plus counted forced stalls.
   initial begin
      ready_out = 1'b0;
      ready_hdr = 1'b0;
      forever begin
         @(posedge clk); #1;
         ready_out = (stall_out == 0) && (rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1);
         if (stall_out > 0) stall_out--;
         ready_hdr = (stall_hdr == 0);
         if (stall_hdr > 0) stall_hdr--;
      end
   end

   // Compare process: every handshake against the model, every stalled cycle for stability.
   initial begin
      beat_t cur, curh, pv, ph, e;
      bit    pstall, phstall;
      pstall = 1'b0; phstall = 1'b0; pv = '0; ph = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pstall = 1'b0; phstall = 1'b0;
         end else begin
            cur  = {data_out, keep_out, last_out};
            curh = {data_hdr, keep_hdr, 1'b0};
            if (pstall)  chk("out_stable", 64'({valid_out, cur}), 64'({1'b1, pv}));
            if (phstall) chk("hdr_stable", 64'({valid_hdr, curh}), 64'({1'b1, ph}));
            if (valid_out && ready_out && !mute) begin
               if (exp_q.size() == 0) chk("out_extra_beat", 64'(exp_q.size()), 64'(1));
               else begin
                  e = exp_q.pop_front();
                  chk("out_beat", 64'(cur), 64'(e));
                  obs_q.push_back(cur);
               end
            end
            if (valid_hdr && ready_hdr && !mute) begin
               if (exp_h.size() == 0) chk("hdr_extra", 64'(exp_h.size()), 64'(1));
               else begin
                  e = exp_h.pop_front();
                  chk("hdr", 64'(curh), 64'(e));
                  obs_h.push_back(curh);
               end
            end
            pstall  = valid_out && !ready_out;  pv = cur;
            phstall = valid_hdr && !ready_hdr;  ph = curh;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      rst_n = 1'b0; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0; hdr_len = '0;
      #1;
      check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 1: S=2, flush path
      load_case1(32'h55667700, 4'hE);
      run_pkt(2, w);
      drain();
      lit_q.push_back(mk(32'hCCDD1122, 4'hF, 1'b0));
      lit_q.push_back(mk(32'h33445566, 4'hF, 1'b0));
      lit_q.push_back(mk(32'h77000000, 4'h8, 1'b1));
      expect_lits("c1", mk(32'hAABB0000, 4'hC, 1'b0));

      // 2: S=2, tail fits in last merged beat
      load_case1(32'h55000000, 4'h8);
      run_pkt(2, w);
      drain();
      lit_q.push_back(mk(32'hCCDD1122, 4'hF, 1'b0));
      lit_q.push_back(mk(32'h33445500, 4'hE, 1'b1));
      expect_lits("c2", mk(32'hAABB0000, 4'hC, 1'b0));

      // 3: S=W pass-through
      in_q.push_back(mk(32'h01020304, 4'hF, 1'b0));
      in_q.push_back(mk(32'hA1A2A3A4, 4'hF, 1'b0));
      in_q.push_back(mk(32'hB1B2B300, 4'hE, 1'b1));
      run_pkt(4, w);
      drain();
      lit_q.push_back(mk(32'hA1A2A3A4, 4'hF, 1'b0));
      lit_q.push_back(mk(32'hB1B2B300, 4'hE, 1'b1));
      expect_lits("c3", mk(32'h01020304, 4'hF, 1'b0));

      // 4: single-beat packets, then back-to-back packets with no gap
      in_q.push_back(mk(32'hAABBCCDD, 4'hF, 1'b1));
      run_pkt(1, w);
      drain();
      lit_q.push_back(mk(32'hBBCCDD00, 4'hE, 1'b1));
      expect_lits("c4a", mk(32'hAA000000, 4'h8, 1'b0));
      in_q.push_back(mk(32'hAABB0000, 4'hC, 1'b1));
      run_pkt(2, w);
      drain();
      expect_lits("c4b", mk(32'hAABB0000, 4'hC, 1'b0));
      in_q.push_back(mk(32'hDEADBEEF, 4'hF, 1'b1));
      run_pkt(3, w);
      load_case1(32'h55667700, 4'hE);
      run_pkt(2, w);
      drain();
      obs_q.delete(); obs_h.delete();

      // 5: random ready_out, header held off, 3-cycle payload stall mid-packet
      rand_rdy = 1'b1;
      stall_hdr = 5;
      in_q.push_back(mk(32'h10203040, 4'hF, 1'b1));
      run_pkt(1, w);
      load_case1(32'h55667700, 4'hE);
      fork
         run_pkt(2, w);
         begin
            repeat (2) @(posedge clk);
            #1 stall_out = 3;
         end
      join
      chk("hdr_stall_blocks_first_beat", 64'(w > 0), 64'(1));
      for (int p = 0; p < 4; p++) begin
         load_case1(32'h55000000 | 32'(p), (p % 2 == 0) ? 4'h8 : 4'hC);
         run_pkt(p + 1, w);
      end
      drain();
      rand_rdy = 1'b0;
      obs_q.delete(); obs_h.delete();

      // 6: reset in the middle of a packet, then a clean packet
      repeat (2) @(posedge clk);
      #1 mute = 1'b1;
      drive_beat(mk(32'hAABBCCDD, 4'hF, 1'b0), 2'd1, w);
      drive_beat(mk(32'h11223344, 4'hF, 1'b0), 2'd1, w);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete(); exp_h.delete(); obs_q.delete(); obs_h.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      mute = 1'b0;
      @(posedge clk); #1;
      load_case1(32'h55667700, 4'hE);
      run_pkt(2, w);
      drain();
      lit_q.push_back(mk(32'hCCDD1122, 4'hF, 1'b0));
      lit_q.push_back(mk(32'h33445566, 4'hF, 1'b0));
      lit_q.push_back(mk(32'h77000000, 4'h8, 1'b1));
      expect_lits("c6", mk(32'hAABB0000, 4'hC, 1'b0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
